mc_control_unit: RTL and testbench

- Multi-cycle successor to the single-cycle opcode decoder.
- Sequences each instruction through FETCH/DECODE/EXEC/MEM/WB and drives datapath enables per state.
- Waits on a memory-ready handshake, with a bounded timeout.
- Sits between the instruction register and the shared-memory datapath; opcode set is unchanged (lw, sw, ori, lui, mul, jr).

---
 rtl/mc_control_unit.sv | 254 +++++++++++++++++++++++++
 tb/tb_mc_control_unit.sv | 216 +++++++++++++++++++++
 2 files changed

// File: rtl/mc_control_unit.sv
// ---------------------------------------------------------------------------
// mc_control_unit
//
// Multi-cycle control unit. Sequences each instruction through
// FETCH -> DECODE -> EXEC -> MEM -> WB and drives the datapath enables that
// belong to each step. Memory accesses (instruction fetch and lw/sw data)
// wait on a mem_ready handshake. A wait counter bounds each wait. If the
// wait runs out, mem_err pulses and the unit goes back to FETCH.
//
// Supported opcodes: lw, sw, ori, lui, mul, jr. Any other opcode raises
// illegal_op in DECODE.
//
// Ports:
//   clk          rising-edge clock
//   rst          synchronous active-high reset
//   instruction  opcode from the IR, sampled only in DECODE
//   mem_ready    memory completes the current request this cycle
//   pc_write     PC update enable
//   ir_write     IR load enable
//   mem_req      memory request (fetch or data)
//   memread, memwrite, memtoreg, reg_write, reg_dst, alusrc, branch
//                datapath controls
//   aluop        ALU operation class, latched in DECODE
//   state        current state, for debug
//   instr_done   one-cycle pulse when an instruction retires
//   illegal_op   one-cycle pulse on an undecodable opcode
//   mem_err      one-cycle pulse when a memory wait times out
//
// Optional feature (macro MUL_MULTICYCLE_EN):
//   When defined, mul stays in EXEC for MUL_CYCLES cycles. A 4-bit counter
//   is loaded on EXEC entry and counts the cycles down.
//   When undefined, mul takes a single EXEC cycle and no counter exists.
// ---------------------------------------------------------------------------
module mc_control_unit #(
    parameter int OPCODE_W    = 6,
    parameter int MEM_TIMEOUT = 15,
    parameter int MUL_CYCLES  = 4
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [OPCODE_W-1:0] instruction,
    input  logic                mem_ready,
    output logic                pc_write,
    output logic                ir_write,
    output logic                mem_req,
    output logic                memread,
    output logic                memwrite,
    output logic                memtoreg,
    output logic                reg_write,
    output logic                reg_dst,
    output logic                alusrc,
    output logic                branch,
    output logic [1:0]          aluop,
    output logic [2:0]          state,
    output logic                instr_done,
    output logic                illegal_op,
    output logic                mem_err
);

    typedef enum logic [2:0] {
        FETCH  = 3'd0,
        DECODE = 3'd1,
        EXEC   = 3'd2,
        MEM    = 3'd3,
        WB     = 3'd4
    } state_t;

    localparam logic [OPCODE_W-1:0] OP_LW  = OPCODE_W'(6'b100011);
    localparam logic [OPCODE_W-1:0] OP_SW  = OPCODE_W'(6'b101011);
    localparam logic [OPCODE_W-1:0] OP_ORI = OPCODE_W'(6'b001101);
    localparam logic [OPCODE_W-1:0] OP_LUI = OPCODE_W'(6'b001111);
    localparam logic [OPCODE_W-1:0] OP_MUL = OPCODE_W'(6'b011010);
    localparam logic [OPCODE_W-1:0] OP_JR  = OPCODE_W'(6'b001000);

    // The counter holds the number of cycles already spent waiting. The
    // current waiting cycle is the last allowed one when the counter is one
    // below the timeout.
    localparam logic [7:0] WAIT_LAST = 8'(MEM_TIMEOUT - 1);

    state_t                state_q, state_d;
    logic [7:0]            waitCnt_q, waitCnt_d;
    logic [OPCODE_W-1:0]   opcode_q, opcode_d;
    logic [1:0]            aluop_q, aluop_d;
    logic                  waitExpired;
`ifdef MUL_MULTICYCLE_EN
    logic [3:0]            mulCnt_q, mulCnt_d;
`endif

    function automatic logic isKnownOp(input logic [OPCODE_W-1:0] op);
        return (op == OP_LW) || (op == OP_SW) || (op == OP_ORI) ||
               (op == OP_LUI) || (op == OP_MUL) || (op == OP_JR);
    endfunction

    // State, latched opcode/aluop and the wait counter. Reset puts the unit
    // back in FETCH and drops any instruction in flight.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= FETCH;
            waitCnt_q <= '0;
            opcode_q  <= '0;
            aluop_q   <= '0;
`ifdef MUL_MULTICYCLE_EN
            mulCnt_q  <= '0;
`endif
        end else begin
            state_q   <= state_d;
            waitCnt_q <= waitCnt_d;
            opcode_q  <= opcode_d;
            aluop_q   <= aluop_d;
`ifdef MUL_MULTICYCLE_EN
            mulCnt_q  <= mulCnt_d;
`endif
        end
    end

    // Next-state and output decode. The outputs come from the current state
    // and the latched opcode. The exceptions are the handshake responses
    // (mem_ready) and the DECODE-time opcode check (instruction).
    always_comb begin
        state_d     = state_q;
        opcode_d    = opcode_q;
        aluop_d     = aluop_q;
        waitCnt_d   = waitCnt_q;
        waitExpired = 1'b0;
`ifdef MUL_MULTICYCLE_EN
        mulCnt_d    = mulCnt_q;
`endif
        pc_write    = 1'b0;
        ir_write    = 1'b0;
        mem_req     = 1'b0;
        memread     = 1'b0;
        memwrite    = 1'b0;
        memtoreg    = 1'b0;
        reg_write   = 1'b0;
        reg_dst     = 1'b0;
        alusrc      = 1'b0;
        branch      = 1'b0;
        instr_done  = 1'b0;
        illegal_op  = 1'b0;
        mem_err     = 1'b0;

        case (state_q)
            FETCH: begin
                mem_req = 1'b1;
                memread = 1'b1;
                if (mem_ready) begin
                    ir_write = 1'b1;
                    pc_write = 1'b1;
                    state_d  = DECODE;
                end else if (waitCnt_q == WAIT_LAST) begin
                    waitExpired = 1'b1;
                    mem_err     = 1'b1;
                    state_d     = FETCH;
                end
            end

            DECODE: begin
                opcode_d = instruction;
                aluop_d  = {instruction[2], instruction[0]};
                if (isKnownOp(instruction)) begin
                    state_d = EXEC;
`ifdef MUL_MULTICYCLE_EN
                    mulCnt_d = 4'(MUL_CYCLES);
`endif
                end else begin
                    illegal_op = 1'b1;
                    state_d    = FETCH;
                end
            end

            EXEC: begin
                alusrc  = (opcode_q == OP_LW) || (opcode_q == OP_SW) ||
                          (opcode_q == OP_ORI) || (opcode_q == OP_LUI);
                reg_dst = (opcode_q == OP_MUL);
                if (opcode_q == OP_JR) begin
                    branch     = 1'b1;
                    pc_write   = 1'b1;
                    instr_done = 1'b1;
                    state_d    = FETCH;
                end else if ((opcode_q == OP_LW) || (opcode_q == OP_SW)) begin
                    state_d = MEM;
                end else if (opcode_q == OP_MUL) begin
`ifdef MUL_MULTICYCLE_EN
                    // The counter was loaded with the full EXEC length on
                    // entry. The cycle that sees 1 is the last one.
                    if (mulCnt_q <= 4'd1) begin
                        state_d = WB;
                    end else begin
                        mulCnt_d = mulCnt_q - 4'd1;
                    end
`else
                    state_d = WB;
`endif
                end else begin
                    state_d = WB;
                end
            end

            MEM: begin
                mem_req  = 1'b1;
                alusrc   = 1'b1;
                memread  = (opcode_q == OP_LW);
                memwrite = (opcode_q == OP_SW);
                if (mem_ready) begin
                    if (opcode_q == OP_SW) begin
                        instr_done = 1'b1;
                        state_d    = FETCH;
                    end else begin
                        state_d = WB;
                    end
                end else if (waitCnt_q == WAIT_LAST) begin
                    // The store is abandoned, so no write strobe is issued
                    // in the abort cycle.
                    waitExpired = 1'b1;
                    memwrite    = 1'b0;
                    mem_err     = 1'b1;
                    state_d     = FETCH;
                end
            end

            WB: begin
                reg_write  = 1'b1;
                memtoreg   = (opcode_q == OP_LW);
                reg_dst    = (opcode_q == OP_MUL);
                instr_done = 1'b1;
                state_d    = FETCH;
            end

            default: begin
                state_d = FETCH;
            end
        endcase

        // The counter restarts whenever FETCH or MEM is entered. A timeout
        // re-enters FETCH even though the state value does not change.
        if (waitExpired || (state_d != state_q)) begin
            waitCnt_d = '0;
        end else if (mem_req && !mem_ready) begin
            waitCnt_d = waitCnt_q + 8'd1;
        end

        // While reset is held, every strobe is forced low. This means an
        // aborted instruction cannot emit a final write pulse.
        if (rst) begin
            {pc_write, ir_write, mem_req, memread, memwrite, memtoreg,
             reg_write, reg_dst, alusrc, branch, instr_done, illegal_op,
             mem_err} = '0;
        end
    end

    assign state = state_q;
    assign aluop = aluop_q;

endmodule

// File: tb/tb_mc_control_unit.sv
// ---------------------------------------------------------------------------
// tb_mc_control_unit
//
// Directed testbench for mc_control_unit. Each cycle drives the opcode and
// mem_ready, then compares the state and the packed control strobes against
// hand-computed values. It also compares aluop after DECODE has latched it.
// ---------------------------------------------------------------------------
module tb_mc_control_unit;

    logic       clk = 1'b0;
    logic       rst;
    logic [5:0] instruction;
    logic       mem_ready;
    logic       pc_write, ir_write, mem_req, memread, memwrite, memtoreg;
    logic       reg_write, reg_dst, alusrc, branch;
    logic [1:0] aluop;
    logic [2:0] state;
    logic       instr_done, illegal_op, mem_err;
    logic [12:0] ctrl;

    int vectorCount = 0;
    int missCount   = 0;

    localparam logic [5:0] OP_LW  = 6'b100011;
    localparam logic [5:0] OP_SW  = 6'b101011;
    localparam logic [5:0] OP_ORI = 6'b001101;
    localparam logic [5:0] OP_LUI = 6'b001111;
    localparam logic [5:0] OP_MUL = 6'b011010;
    localparam logic [5:0] OP_JR  = 6'b001000;
    localparam logic [5:0] OP_BAD = 6'b111111;

    // One bit per control strobe, in the same order as the ctrl packing
    localparam logic [12:0] PCW  = 13'h1000;
    localparam logic [12:0] IRW  = 13'h0800;
    localparam logic [12:0] REQ  = 13'h0400;
    localparam logic [12:0] RD   = 13'h0200;
    localparam logic [12:0] WR   = 13'h0100;
    localparam logic [12:0] M2R  = 13'h0080;
    localparam logic [12:0] RW   = 13'h0040;
    localparam logic [12:0] RDST = 13'h0020;
    localparam logic [12:0] ASRC = 13'h0010;
    localparam logic [12:0] BR   = 13'h0008;
    localparam logic [12:0] DONE = 13'h0004;
    localparam logic [12:0] ILL  = 13'h0002;
    localparam logic [12:0] ERR  = 13'h0001;
    localparam logic [12:0] FETCH_OK = PCW | IRW | REQ | RD;

`ifdef MUL_MULTICYCLE_EN
    localparam int MUL_EXEC = 4;
`else
    localparam int MUL_EXEC = 1;
`endif

    mc_control_unit #(
        .OPCODE_W    (6),
        .MEM_TIMEOUT (15),
        .MUL_CYCLES  (4)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .instruction (instruction),
        .mem_ready   (mem_ready),
        .pc_write    (pc_write),
        .ir_write    (ir_write),
        .mem_req     (mem_req),
        .memread     (memread),
        .memwrite    (memwrite),
        .memtoreg    (memtoreg),
        .reg_write   (reg_write),
        .reg_dst     (reg_dst),
        .alusrc      (alusrc),
        .branch      (branch),
        .aluop       (aluop),
        .state       (state),
        .instr_done  (instr_done),
        .illegal_op  (illegal_op),
        .mem_err     (mem_err)
    );

    assign ctrl = {pc_write, ir_write, mem_req, memread, memwrite, memtoreg,
                   reg_write, reg_dst, alusrc, branch, instr_done, illegal_op,
                   mem_err};

    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [15:0] observed,
                               input logic [15:0] expected);
        vectorCount++;
        if (observed !== expected) begin
            missCount++;
            $display("[TB] FAIL %s: observed %0h, expected %0h", tag, observed, expected);
        end
    endtask

    // Inputs change just after a rising edge. Outputs are sampled mid-cycle.
    task automatic applyStimulus(input logic [5:0] instr, input logic ready);
        instruction = instr;
        mem_ready   = ready;
        #3;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic runCycle(input string tag, input logic [5:0] instr, input logic ready,
                            input logic [2:0] expState, input logic [12:0] expCtrl);
        applyStimulus(instr, ready);
        checkOutput({tag, " state"}, 16'(state), 16'(expState));
        checkOutput({tag, " ctrl"}, 16'(ctrl), 16'(expCtrl));
        tick();
    endtask

    initial begin
        rst         = 1'b1;
        instruction = '0;
        mem_ready   = 1'b0;
        tick();
        tick();

        // While reset is held, the unit sits in FETCH with every strobe low.
        applyStimulus(OP_LW, 1'b1);
        checkOutput("reset state", 16'(state), 16'd0);
        checkOutput("reset ctrl", 16'(ctrl), 16'd0);
        checkOutput("reset aluop", 16'(aluop), 16'd0);
        tick();
        rst = 1'b0;

        // lw with an always-ready memory: five cycles
        runCycle("lw fetch", OP_LW, 1'b1, 3'd0, FETCH_OK);
        runCycle("lw decode", OP_LW, 1'b1, 3'd1, 13'h0);
        runCycle("lw exec", OP_LW, 1'b1, 3'd2, ASRC);
        runCycle("lw mem", OP_LW, 1'b1, 3'd3, REQ | RD | ASRC);
        runCycle("lw wb", OP_LW, 1'b1, 3'd4, RW | M2R | DONE);

        // sw with the data access stalled for three cycles
        runCycle("sw fetch", OP_SW, 1'b1, 3'd0, FETCH_OK);
        runCycle("sw decode", OP_SW, 1'b1, 3'd1, 13'h0);
        runCycle("sw exec", OP_SW, 1'b1, 3'd2, ASRC);
        for (int i = 0; i < 3; i++) begin
            runCycle("sw mem stall", OP_SW, 1'b0, 3'd3, REQ | WR | ASRC);
        end
        runCycle("sw mem done", OP_SW, 1'b1, 3'd3, REQ | WR | ASRC | DONE);

        // jr retires directly from EXEC
        runCycle("jr fetch", OP_JR, 1'b1, 3'd0, FETCH_OK);
        runCycle("jr decode", OP_JR, 1'b1, 3'd1, 13'h0);
        runCycle("jr exec", OP_JR, 1'b1, 3'd2, PCW | BR | DONE);
        checkOutput("jr aluop", 16'(aluop), 16'h0);

        // An undecodable opcode is dropped in DECODE
        runCycle("bad fetch", OP_BAD, 1'b1, 3'd0, FETCH_OK);
        runCycle("bad decode", OP_BAD, 1'b1, 3'd1, ILL);

        // ori: aluop is {bit2, bit0} = 2'b11
        runCycle("ori fetch", OP_ORI, 1'b1, 3'd0, FETCH_OK);
        runCycle("ori decode", OP_ORI, 1'b1, 3'd1, 13'h0);
        runCycle("ori exec", OP_ORI, 1'b1, 3'd2, ASRC);
        checkOutput("ori aluop", 16'(aluop), 16'h3);
        runCycle("ori wb", OP_ORI, 1'b1, 3'd4, RW | DONE);

        // lui
        runCycle("lui fetch", OP_LUI, 1'b1, 3'd0, FETCH_OK);
        runCycle("lui decode", OP_LUI, 1'b1, 3'd1, 13'h0);
        runCycle("lui exec", OP_LUI, 1'b1, 3'd2, ASRC);
        runCycle("lui wb", OP_LUI, 1'b1, 3'd4, RW | DONE);
        checkOutput("lui aluop", 16'(aluop), 16'h3);

        // mul: EXEC length depends on the build option
        runCycle("mul fetch", OP_MUL, 1'b1, 3'd0, FETCH_OK);
        runCycle("mul decode", OP_MUL, 1'b1, 3'd1, 13'h0);
        for (int i = 0; i < MUL_EXEC; i++) begin
            runCycle("mul exec", OP_MUL, 1'b1, 3'd2, RDST);
        end
        runCycle("mul wb", OP_MUL, 1'b1, 3'd4, RW | RDST | DONE);
        checkOutput("mul aluop", 16'(aluop), 16'h0);

        // Fetch that never completes: the error fires on the 15th waiting cycle
        for (int i = 0; i < 14; i++) begin
            runCycle("fetch wait", OP_BAD, 1'b0, 3'd0, REQ | RD);
        end
        runCycle("fetch timeout", OP_BAD, 1'b0, 3'd0, REQ | RD | ERR);

        // Ready on exactly the 15th cycle: completion wins
        for (int i = 0; i < 14; i++) begin
            runCycle("fetch wait2", OP_BAD, 1'b0, 3'd0, REQ | RD);
        end
        runCycle("fetch late ready", OP_BAD, 1'b1, 3'd0, FETCH_OK);
        runCycle("late decode", OP_BAD, 1'b1, 3'd1, ILL);

        // lw whose data access times out
        runCycle("lwto fetch", OP_LW, 1'b1, 3'd0, FETCH_OK);
        runCycle("lwto decode", OP_LW, 1'b1, 3'd1, 13'h0);
        runCycle("lwto exec", OP_LW, 1'b1, 3'd2, ASRC);
        for (int i = 0; i < 14; i++) begin
            runCycle("lwto mem wait", OP_LW, 1'b0, 3'd3, REQ | RD | ASRC);
        end
        runCycle("lwto mem timeout", OP_LW, 1'b0, 3'd3, REQ | RD | ASRC | ERR);

        // Reset during mul EXEC aborts the instruction without a register write
        runCycle("rmul fetch", OP_MUL, 1'b1, 3'd0, FETCH_OK);
        runCycle("rmul decode", OP_MUL, 1'b1, 3'd1, 13'h0);
        rst = 1'b1;
        runCycle("rmul exec in reset", OP_MUL, 1'b1, 3'd2, 13'h0);
        rst = 1'b0;
        runCycle("fetch after reset", OP_LUI, 1'b1, 3'd0, FETCH_OK);
        runCycle("post-reset decode", OP_LUI, 1'b1, 3'd1, 13'h0);
        runCycle("post-reset exec", OP_LUI, 1'b1, 3'd2, ASRC);
        runCycle("post-reset wb", OP_LUI, 1'b1, 3'd4, RW | DONE);

        $display("== %0d vectors applied, %0d miscompares ==", vectorCount, missCount);
        $finish;
    end

endmodule
